tmds_channel_decoder: RTL

//  Receive-side counterpart of the HDMI/DVI TMDS encoder: takes one 10-bit TMDS channel word per clk_sys
//  (parallel, bit 0 = first serial bit), finds symbol alignment by sliding a 10-bit window over two

---
 rtl/tmds_channel_decoder_if.sv | 21 ++
 rtl/tmds_channel_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder_if.sv
// Raw channel-word input and decoded outputs of one TMDS receive channel.
interface tmds_channel_decoder_if;
  logic [9:0] sym_i;
  logic [7:0] data_o;
  logic       de_o;
  logic [1:0] ctrl_o;
  logic       locked_o;
  logic [3:0] offset_o;

  // Source side: supplies channel words and observes the decode.
  modport master (
    output sym_i,
    input  data_o, de_o, ctrl_o, locked_o, offset_o
  );

  // Decoder side.
  modport slave (
    input  sym_i,
    output data_o, de_o, ctrl_o, locked_o, offset_o
  );
endinterface

// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: finds 10-bit symbol alignment by sliding a window
// over two consecutive channel words, locks on a run of control tokens,
// then decodes control tokens and 8b/10b data with a fixed two-stage pipeline.
module tmds_channel_decoder #(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 64,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input logic                   clk_sys,
  input logic                   rst,
  tmds_channel_decoder_if.slave bus
);

  localparam int TOK_W  = $clog2(LOCK_COUNT + 1);
  localparam int TMO_W  = $clog2(SEARCH_TIMEOUT + 1);
  localparam int LOSS_W = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [TOK_W-1:0]  TOK_LAST  = TOK_W'(LOCK_COUNT - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SEARCH_TIMEOUT - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);

  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state_q;
  logic [9:0]        sym_q;       // previous channel word
  logic [9:0]        s1_win_q;    // stage1: aligned symbol
  logic              s1_valid_q;  // 0 for the one symbol captured at the old offset
  logic [3:0]        offset_q;
  logic [TOK_W-1:0]  tok_cnt_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [LOSS_W-1:0] loss_cnt_q;
  logic              locked_q;
  logic [7:0]        data_q;
  logic              de_q;
  logic [1:0]        ctrl_q;

  logic [19:0] cat;
  logic [19:0] cat_sh;
  logic [9:0]  win;
  logic        s1_is_tok;
  logic [1:0]  s1_tok_val;
  logic [7:0]  s1_q;
  logic [7:0]  s1_data;
  logic [3:0]  offset_next;
  logic        lock_hit;
  logic        tmo_hit;
  logic        loss_hit;
  logic        locked_next;

  // Select the 10-bit symbol window from the current and previous word.
  always_comb begin
    cat    = {bus.sym_i, sym_q};
    cat_sh = cat >> offset_q;
    win    = cat_sh[9:0];
  end

  // Classify the stage1 symbol and run the 8b/10b data decode on it.
  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    s1_is_tok  = 1'b1;
    s1_tok_val = 2'b00;
    case (s1_win_q)
      TOKEN_C00: s1_tok_val = 2'b00;
      TOKEN_C01: s1_tok_val = 2'b01;
      TOKEN_C10: s1_tok_val = 2'b10;
      TOKEN_C11: s1_tok_val = 2'b11;
      default:   s1_is_tok  = 1'b0;
    endcase
    s1_q       = s1_win_q[9] ? ~s1_win_q[7:0] : s1_win_q[7:0];
    s1_data    = '0;
    s1_data[0] = s1_q[0];
    for (int i = 1; i < 8; i++) begin
      s1_data[i] = s1_win_q[8] ? (s1_q[i] ^ s1_q[i-1]) : ~(s1_q[i] ^ s1_q[i-1]);
    end
  end

  // Lock / timeout / loss decisions for this edge, and the resulting lock state.
  always_comb begin
    offset_next = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
    lock_hit    = s1_valid_q && s1_is_tok && (tok_cnt_q == TOK_LAST);
    tmo_hit     = (tmo_q == TMO_LAST);
    loss_hit    = !s1_is_tok && (loss_cnt_q == LOSS_LAST);
    locked_next = (state_q == SEARCH) ? lock_hit : !loss_hit;
  end

  // Word history, stage1, alignment FSM and registered outputs.
  // NOTE: the word history and stage1 are reset too, so no stale symbol can
  // be decoded or counted right after reset.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q    <= SEARCH;
      sym_q      <= '0;
      s1_win_q   <= '0;
      s1_valid_q <= 1'b1;
      offset_q   <= '0;
      tok_cnt_q  <= '0;
      tmo_q      <= '0;
      loss_cnt_q <= '0;
      locked_q   <= 1'b0;
      data_q     <= '0;
      de_q       <= 1'b0;
      ctrl_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      sym_q      <= bus.sym_i;
      s1_win_q   <= win;
      s1_valid_q <= 1'b1;

      if (!s1_valid_q) begin
        de_q   <= 1'b0;
        data_q <= '0;
      end else if (s1_is_tok) begin
        ctrl_q <= s1_tok_val;
        de_q   <= 1'b0;
        data_q <= '0;
      end else begin
        de_q   <= locked_next;
        data_q <= locked_next ? s1_data : '0;
      end

      case (state_q)
        SEARCH: begin
          if (lock_hit) begin
            state_q    <= LOCKED;
            locked_q   <= 1'b1;
            loss_cnt_q <= '0;
            tok_cnt_q  <= '0;
            tmo_q      <= '0;
          end else if (tmo_hit) begin
            offset_q   <= offset_next;
            tok_cnt_q  <= '0;
            tmo_q      <= '0;
            s1_valid_q <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
            if (s1_valid_q) begin
              tok_cnt_q <= s1_is_tok ? tok_cnt_q + TOK_W'(1) : '0;
            end
          end
        end
        LOCKED: begin
          if (s1_is_tok) begin
            loss_cnt_q <= '0;
          end else if (loss_hit) begin
            state_q    <= SEARCH;
            locked_q   <= 1'b0;
            offset_q   <= offset_next;
            tok_cnt_q  <= '0;
            tmo_q      <= '0;
            loss_cnt_q <= '0;
            s1_valid_q <= 1'b0;
          end else begin
            loss_cnt_q <= loss_cnt_q + LOSS_W'(1);
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign bus.data_o   = data_q;
  assign bus.de_o     = de_q;
  assign bus.ctrl_o   = ctrl_q;
  assign bus.locked_o = locked_q;
  assign bus.offset_o = offset_q;

endmodule
